// File: rtl/data_check_pkg.sv
// Shared constants for the data_check stream checker and its Data_gen peer.
// Holds the FSM encoding, the default word width/step, and a width helper
// for the run-length counters.
package data_check_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int STEP_DEF   = 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_LOST   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LOCKED = ST_LOCKED,
    S_LOST   = ST_LOST
  } state_t;

  // Bits needed to hold a run counter that counts up to thresh.
  function automatic int run_width(input int thresh);
    return (thresh < 1) ? 1 : $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/data_check_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
// Clear has priority over inc; the count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count events, stick at the maximum value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_check.sv
// Receive-side checker for the Data_gen stream.
// Handshake: inc is a pure valid strobe with no back-pressure; data is
// sampled on every rising clk edge where inc=1 and ignored otherwise.
// The first word after reset locks the checker; afterwards each word must
// equal the previous word + STEP (mod 2^DATA_W). Loss of sync is declared
// after LOSS_THRESH consecutive mismatches, recovery after LOCK_THRESH
// consecutive matches. fsm_state exposes the FSM for debug.
// Optional feature macro: DATA_CHECK_CAPTURE_EN adds cap_exp/cap_got, which
// latch the expected and received word of the first mismatch.
module data_check
  import data_check_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 4,
  parameter int LOCK_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic              locked,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt,
`ifdef DATA_CHECK_CAPTURE_EN
  output logic [DATA_W-1:0] cap_exp,
  output logic [DATA_W-1:0] cap_got,
`endif
  output logic [1:0]        fsm_state
);

  localparam int MISS_W = run_width(LOSS_THRESH);
  localparam int HIT_W  = run_width(LOCK_THRESH);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   expected_q, expected_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic                mismatch;

  // Next-state, expected-word and run-length decisions for a sampled word.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    miss_d     = miss_q;
    hit_d      = hit_q;
    mismatch   = 1'b0;
    if (inc) begin
      // Always resync to the received word, matched or not.
      expected_d = data + DATA_W'(STEP);
      case (state_q)
        S_IDLE: begin
          state_d = S_LOCKED;
          miss_d  = '0;
          hit_d   = '0;
        end
        S_LOCKED: begin
          if (data != expected_q) begin
            mismatch = 1'b1;
            if (miss_q >= MISS_W'(LOSS_THRESH - 1)) begin
              state_d = S_LOST;
              miss_d  = '0;
              hit_d   = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        S_LOST: begin
          if (data != expected_q) begin
            mismatch = 1'b1;
            hit_d    = '0;
          end else if (hit_q >= HIT_W'(LOCK_THRESH - 1)) begin
            state_d = S_LOCKED;
            miss_d  = '0;
            hit_d   = '0;
          end else begin
            hit_d = hit_q + HIT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM state, expected word and run counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      expected_q <= '0;
      miss_q     <= '0;
      hit_q      <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      miss_q     <= miss_d;
      hit_q      <= hit_d;
    end
  end

  // Sticky error flag; clear beats a same-cycle mismatch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_flag <= 1'b0;
    end else if (clear) begin
      err_flag <= 1'b0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (mismatch),
    .cnt   (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (inc),
    .cnt   (word_cnt)
  );

  assign locked    = (state_q == S_LOCKED);
  assign fsm_state = state_q;

`ifdef DATA_CHECK_CAPTURE_EN
  logic cap_done;

  // Latch the first mismatching pair after reset/clear and hold it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_done <= 1'b0;
      cap_exp  <= '0;
      cap_got  <= '0;
    end else if (clear) begin
      cap_done <= 1'b0;
      cap_exp  <= '0;
      cap_got  <= '0;
    end else if (mismatch && !cap_done) begin
      cap_done <= 1'b1;
      cap_exp  <= expected_q;
      cap_got  <= data;
    end
  end
`endif

endmodule

// File: tb/tb_data_check.sv
// Self-checking bench for data_check: directed sequences, a vector table and
// a randomized phase checked against a behavioural stream model. A second
// instance with 3-bit counters shares the stimulus to exercise saturation.
module tb_data_check;

  localparam int DW   = 16;
  localparam int STEP = 1;
  localparam int CW   = 16;
  localparam int CWS  = 3;
  localparam int LOSS = 4;
  localparam int LOCK = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          inc   = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] data  = '0;

  logic          locked, err_flag;
  logic [CW-1:0] err_cnt, word_cnt;
  logic [1:0]    fsm_state;
  logic          locked_s, err_flag_s;
  logic [CWS-1:0] err_cnt_s, word_cnt_s;
  logic [1:0]    fsm_state_s;
`ifdef DATA_CHECK_CAPTURE_EN
  logic [DW-1:0] cap_exp, cap_got, cap_exp_s, cap_got_s;
`endif

  data_check #(.DATA_W(DW), .STEP(STEP), .CNT_W(CW),
               .LOSS_THRESH(LOSS), .LOCK_THRESH(LOCK)) dut (
    .clk(clk), .reset(reset), .inc(inc), .data(data), .clear(clear),
    .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt), .word_cnt(word_cnt),
`ifdef DATA_CHECK_CAPTURE_EN
    .cap_exp(cap_exp), .cap_got(cap_got),
`endif
    .fsm_state(fsm_state)
  );

  data_check #(.DATA_W(DW), .STEP(STEP), .CNT_W(CWS),
               .LOSS_THRESH(LOSS), .LOCK_THRESH(LOCK)) dut_s (
    .clk(clk), .reset(reset), .inc(inc), .data(data), .clear(clear),
    .locked(locked_s), .err_flag(err_flag_s), .err_cnt(err_cnt_s), .word_cnt(word_cnt_s),
`ifdef DATA_CHECK_CAPTURE_EN
    .cap_exp(cap_exp_s), .cap_got(cap_got_s),
`endif
    .fsm_state(fsm_state_s)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model of the stream: 0 = waiting for first word,
  // 1 = in sync, 2 = sync lost. Counters kept unbounded, clipped on compare.
  int m_state, m_exp, m_miss, m_hit, m_err, m_words;
  bit m_flag, m_cap_done;
  int m_cap_exp, m_cap_got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_miss = 0; m_hit = 0;
    m_err = 0; m_words = 0; m_flag = 0;
    m_cap_done = 0; m_cap_exp = 0; m_cap_got = 0;
  endtask

  task automatic model_apply(input bit i, input int d, input bit c);
    bit mism;
    mism = 0;
    if (i) begin
      if (m_state == 0) begin
        m_state = 1; m_miss = 0; m_hit = 0;
      end else begin
        mism = (d != m_exp);
        if (m_state == 1) begin
          m_miss = mism ? m_miss + 1 : 0;
          if (m_miss >= LOSS) begin m_state = 2; m_miss = 0; m_hit = 0; end
        end else begin
          m_hit = mism ? 0 : m_hit + 1;
          if (m_hit >= LOCK) begin m_state = 1; m_miss = 0; m_hit = 0; end
        end
      end
    end
    if (c) begin
      m_err = 0; m_words = 0; m_flag = 0;
      m_cap_done = 0; m_cap_exp = 0; m_cap_got = 0;
    end else if (i) begin
      m_words++;
      if (mism) begin
        m_err++;
        m_flag = 1;
        if (!m_cap_done) begin
          m_cap_done = 1; m_cap_exp = m_exp; m_cap_got = d;
        end
      end
    end
    if (i) m_exp = (d + STEP) % (1 << DW);
  endtask

  task automatic compare_model();
    check("m_locked",     locked,      (m_state == 1));
    check("m_err_flag",   err_flag,    m_flag);
    check("m_err_cnt",    err_cnt,     clip(m_err, CW));
    check("m_word_cnt",   word_cnt,    clip(m_words, CW));
    check("m_fsm_state",  fsm_state,   m_state);
    check("s_err_cnt",    err_cnt_s,   clip(m_err, CWS));
    check("s_word_cnt",   word_cnt_s,  clip(m_words, CWS));
`ifdef DATA_CHECK_CAPTURE_EN
    check("m_cap_exp",    cap_exp,     m_cap_exp);
    check("m_cap_got",    cap_got,     m_cap_got);
`endif
  endtask

  // Driver: present one cycle of inputs, let the edge pass, then check.
  task automatic step(input bit i, input logic [DW-1:0] d, input bit c);
    inc = i; data = d; clear = c;
    @(posedge clk);
    #1;
    model_apply(i, int'(d), c);
    inc = 1'b0; clear = 1'b0;
    compare_model();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; inc = 1'b0; clear = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    compare_model();
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          exp_locked;
    logic          exp_flag;
    logic [CW-1:0] exp_err;
    logic [CW-1:0] exp_words;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Streams 5,6,9,10,11 then four scattered words and two good ones.
    vecs[0]  = '{16'd5,      1'b1, 1'b0, 16'd0, 16'd1};
    vecs[1]  = '{16'd6,      1'b1, 1'b0, 16'd0, 16'd2};
    vecs[2]  = '{16'd9,      1'b1, 1'b1, 16'd1, 16'd3};
    vecs[3]  = '{16'd10,     1'b1, 1'b1, 16'd1, 16'd4};
    vecs[4]  = '{16'd11,     1'b1, 1'b1, 16'd1, 16'd5};
    vecs[5]  = '{16'h1000,   1'b1, 1'b1, 16'd2, 16'd6};
    vecs[6]  = '{16'h3000,   1'b1, 1'b1, 16'd3, 16'd7};
    vecs[7]  = '{16'h5000,   1'b1, 1'b1, 16'd4, 16'd8};
    vecs[8]  = '{16'h7000,   1'b0, 1'b1, 16'd5, 16'd9};
    vecs[9]  = '{16'h7001,   1'b0, 1'b1, 16'd5, 16'd10};
    vecs[10] = '{16'h7002,   1'b1, 1'b1, 16'd5, 16'd11};

    model_reset();

    // Test 1: reset held for 4 cycles.
    do_reset(4);
    check("t1_locked",   locked,   1'b0);
    check("t1_err_flag", err_flag, 1'b0);
    check("t1_err_cnt",  err_cnt,  16'd0);
    check("t1_word_cnt", word_cnt, 16'd0);

    // Test 2: 100 sequential words from 0.
    step(1'b1, 16'd0, 1'b0);
    check("t2_first_locked", locked, 1'b1);
    for (int i = 1; i < 100; i++) step(1'b1, 16'(i), 1'b0);
    check("t2_err_cnt",  err_cnt,  16'd0);
    check("t2_word_cnt", word_cnt, 16'd100);
    check("t2_locked",   locked,   1'b1);

    // Test 3: wrap across 0xFFFF.
    do_reset(1);
    step(1'b1, 16'hFFFE, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'h0001, 1'b0);
    check("t3_err_cnt",  err_cnt,  16'd0);
    check("t3_err_flag", err_flag, 1'b0);
    check("t3_locked",   locked,   1'b1);

    // Tests 4 and 5: vector table.
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, vecs[k].data, 1'b0);
      check("tv_locked",   locked,   vecs[k].exp_locked);
      check("tv_err_flag", err_flag, vecs[k].exp_flag);
      check("tv_err_cnt",  err_cnt,  vecs[k].exp_err);
      check("tv_word_cnt", word_cnt, vecs[k].exp_words);
    end
`ifdef DATA_CHECK_CAPTURE_EN
    check("t4_cap_exp", cap_exp, 16'd7);
    check("t4_cap_got", cap_got, 16'd9);
`endif
    for (int k = 5; k < 11; k++) begin
      step(1'b1, vecs[k].data, 1'b0);
      check("tv_locked",   locked,   vecs[k].exp_locked);
      check("tv_err_flag", err_flag, vecs[k].exp_flag);
      check("tv_err_cnt",  err_cnt,  vecs[k].exp_err);
      check("tv_word_cnt", word_cnt, vecs[k].exp_words);
    end
`ifdef DATA_CHECK_CAPTURE_EN
    check("t5_cap_exp_held", cap_exp, 16'd7);
    check("t5_cap_got_held", cap_got, 16'd9);
`endif

    // Test 6: clear with a mismatching word, then reset mid-stream.
    step(1'b1, 16'h9999, 1'b1);
    check("t6_clr_err_cnt",  err_cnt,  16'd0);
    check("t6_clr_word_cnt", word_cnt, 16'd0);
    check("t6_clr_err_flag", err_flag, 1'b0);
    check("t6_clr_locked",   locked,   1'b1);
`ifdef DATA_CHECK_CAPTURE_EN
    check("t6_clr_cap_exp", cap_exp, 16'd0);
    check("t6_clr_cap_got", cap_got, 16'd0);
`endif
    step(1'b1, 16'h999A, 1'b0);
    check("t6_resync_err", err_cnt, 16'd0);
    do_reset(1);
    check("t6_rst_locked", locked,    1'b0);
    check("t6_rst_state",  fsm_state, 2'd0);
    step(1'b1, 16'h1234, 1'b0);
    check("t6_relock",     locked,   1'b1);
    check("t6_relock_err", err_cnt,  16'd0);
    step(1'b1, 16'h1235, 1'b0);
    check("t6_word_cnt",   word_cnt, 16'd2);
    check("t6_err_flag",   err_flag, 1'b0);

    // Randomized phase: alternating mostly-good and mostly-bad stretches.
    do_reset(2);
    for (int n = 0; n < 600; n++) begin
      bit            ri, rc;
      logic [DW-1:0] rd;
      int            good_pct;
      good_pct = ((n / 60) % 2 == 1) ? 25 : 85;
      ri = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 99) < good_pct) ? DW'(m_exp) : DW'($urandom_range(0, 65535));
      rc = ($urandom_range(0, 79) == 0);
      step(ri, rd, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
